// File: rtl/deser_rx_pkg.sv
// Shared constants, register map and FSM state type for the serial-frame receiver.
package deser_rx_pkg;

    localparam int WORD_W = 10;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;
    localparam logic [1:0] ADR_FRAMES = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_ABORT = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    function automatic logic [31:0] data_word(input logic valid, input logic [WORD_W-1:0] w);
        return {valid, 21'h0, w};
    endfunction

endpackage

// File: rtl/deser_rx_wb_if.sv
// Wishbone slave bundle for deser_rx_wb; the master drives requests, the slave answers.
interface deser_rx_wb_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
    modport slave  (input CYC_I, STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/deser_rx_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop happens in the same cycle.
module deser_rx_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign level = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer, count and storage update.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/deser_rx_wb.sv
// Serial-frame receiver (10-bit LSB-first) with FIFO and Wishbone read port.
// Define DESER_RX_SYNC_EN to add a 2-flop synchronizer on ser_ena_i/ser_data_i.
module deser_rx_wb
    import deser_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    input  logic         ser_ena_i,
    input  logic         ser_data_i,
    deser_rx_wb_if.slave wb,
    output logic         irq_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e          state_q, state_d;
    logic               ena_r_q, ena_r_d, ena_prev_q, ena_prev_d, data_r_q, data_r_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic               push_q, push_d;
    logic               en_q, en_d, ovf_q, ovf_d, abort_q, abort_d;
    logic [15:0]        frames_q, frames_d;
    logic               ack_q, ack_d, irq_q, irq_d;
    logic [31:0]        dat_o_q, dat_o_d;

    logic               ena_in_s, data_in_s, ena_fall_s;
    logic               req_s, rd_s, ctrl_wr_s, clr_s, pop_s;
    logic               sample_s, abort_evt_s;
    logic [31:0]        rd_data_s;
    logic [WORD_W-1:0]  fifo_rdata_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [LVL_W-1:0]   fifo_level_s;
    logic               unused_s;

`ifdef DESER_RX_SYNC_EN
    logic [1:0] sync_ena_q, sync_ena_d, sync_data_q, sync_data_d;

    // Two-stage synchronizer ahead of the input register.
    always_comb begin
        sync_ena_d  = {sync_ena_q[0], ser_ena_i};
        sync_data_d = {sync_data_q[0], ser_data_i};
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_ena_q  <= 2'b11;
            sync_data_q <= 2'b00;
        end else begin
            sync_ena_q  <= sync_ena_d;
            sync_data_q <= sync_data_d;
        end
    end

    assign ena_in_s  = sync_ena_q[1];
    assign data_in_s = sync_data_q[1];
`else
    assign ena_in_s  = ser_ena_i;
    assign data_in_s = ser_data_i;
`endif

    assign ena_fall_s = ena_prev_q & ~ena_r_q;
    assign req_s      = wb.CYC_I & wb.STB_I & ~ack_q;
    assign rd_s       = req_s & ~wb.WE_I;
    assign ctrl_wr_s  = req_s & wb.WE_I & (wb.ADR_I[3:2] == ADR_CTRL);
    assign clr_s      = ctrl_wr_s & wb.DAT_I[CTRL_CLR];
    assign pop_s      = rd_s & (wb.ADR_I[3:2] == ADR_DATA) & ~fifo_empty_s;
    assign unused_s   = ^{wb.ADR_I[31:4], wb.ADR_I[1:0], wb.DAT_I[31:2]};

    deser_rx_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK_I),
        .rst   (RST_I),
        .flush (clr_s),
        .push  (push_q & ~clr_s),
        .pop   (pop_s),
        .wdata (shift_q),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // FSM state register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: CLR also abandons the frame in progress so nothing lands after a flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en_q && ena_fall_s && !clr_s) state_d = SHIFT;
                else                              state_d = IDLE;
            end
            SHIFT: begin
                if (!en_q || clr_s || ena_r_q) state_d = IDLE;
                else                           state_d = SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing, frame assembly and sticky flags.
    always_comb begin
        ena_r_d     = ena_in_s;
        ena_prev_d  = ena_r_q;
        data_r_d    = data_in_s;
        sample_s    = (state_q == SHIFT) && (state_d == SHIFT) && (clk_cnt_q == SAMPLE_AT);
        abort_evt_s = (state_q == SHIFT) && en_q && !clr_s && ena_r_q && (bit_cnt_q != 4'd0);
        shift_d     = sample_s ? {data_r_q, shift_q[WORD_W-1:1]} : shift_q;
        push_d      = sample_s && (bit_cnt_q == 4'd9);
        if (state_q == SHIFT && state_d == SHIFT) begin
            clk_cnt_d = (clk_cnt_q == CNT_LAST) ? '0 : clk_cnt_q + CNT_W'(1);
        end else begin
            clk_cnt_d = '0;
        end
        if (state_d != SHIFT) begin
            bit_cnt_d = 4'd0;
        end else if (sample_s) begin
            bit_cnt_d = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
        en_d = ctrl_wr_s ? wb.DAT_I[CTRL_EN] : en_q;
        if (clr_s) begin
            ovf_d    = 1'b0;
            abort_d  = 1'b0;
            frames_d = 16'd0;
        end else begin
            ovf_d    = ovf_q | (push_q & fifo_full_s & ~pop_s);
            abort_d  = abort_q | abort_evt_s;
            frames_d = push_q ? frames_q + 16'd1 : frames_q;
        end
    end

    // Register read mux and bus/irq outputs.
    always_comb begin
        rd_data_s = 32'h0;
        case (wb.ADR_I[3:2])
            ADR_DATA:   rd_data_s = fifo_empty_s ? 32'h0 : data_word(1'b1, fifo_rdata_s);
            ADR_STATUS: rd_data_s = {16'h0, 8'(fifo_level_s), 4'h0,
                                     abort_q, ovf_q, fifo_full_s, fifo_empty_s};
            ADR_CTRL:   rd_data_s = {31'h0, en_q};
            ADR_FRAMES: rd_data_s = {16'h0, frames_q};
            default:    rd_data_s = 32'h0;
        endcase
        ack_d   = req_s;
        dat_o_d = rd_s ? rd_data_s : 32'h0;
        irq_d   = en_q & ~fifo_empty_s;
    end

    // Datapath and register-file flops.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ena_r_q    <= 1'b1;
            ena_prev_q <= 1'b1;
            data_r_q   <= 1'b0;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            en_q       <= 1'b0;
            ovf_q      <= 1'b0;
            abort_q    <= 1'b0;
            frames_q   <= 16'd0;
            ack_q      <= 1'b0;
            dat_o_q    <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            ena_r_q    <= ena_r_d;
            ena_prev_q <= ena_prev_d;
            data_r_q   <= data_r_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            abort_q    <= abort_d;
            frames_q   <= frames_d;
            ack_q      <= ack_d;
            dat_o_q    <= dat_o_d;
            irq_q      <= irq_d;
        end
    end

    assign wb.ACK_O = ack_q;
    assign wb.DAT_O = dat_o_q;
    assign irq_o    = irq_q;
endmodule

// File: tb/tb_deser_rx_wb.sv
// Scoreboard bench for deser_rx_wb: bus reads queue expected DAT_O, a negedge monitor checks each ACK.
module tb_deser_rx_wb;
    localparam int CPB = 4;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;
    logic ser_ena_i = 1'b1;
    logic ser_data_i = 1'b0;
    logic irq_o;

    deser_rx_wb_if wb();

    deser_rx_wb #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .ser_ena_i  (ser_ena_i),
        .ser_data_i (ser_data_i),
        .wb         (wb),
        .irq_o      (irq_o)
    );

    always #5 CLK_I = ~CLK_I;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];
    logic [31:0] mon_e;
    bit          mon_c;
    string       mon_n;
    logic [9:0]  tx_words [32];

    // Monitor: every ACK consumes one scoreboard entry.
    always @(negedge CLK_I) begin
        if (wb.ACK_O) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: got ACK with DAT_O=%h, expected no ACK", wb.DAT_O);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = chk_q.pop_front();
                mon_n = name_q.pop_front();
                if (mon_c) begin
                    n_cmp++;
                    if (wb.DAT_O !== mon_e) begin
                        n_fail++;
                        $display("FAIL %s: DAT_O=%h expected %h", mon_n, wb.DAT_O, mon_e);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [31:0] exp, input bit chk, input string nm);
        bit got = 1'b0;
        exp_q.push_back(exp);
        chk_q.push_back(chk);
        name_q.push_back(nm);
        wb.CYC_I = 1'b1;
        wb.STB_I = 1'b1;
        wb.WE_I  = we;
        wb.ADR_I = adr;
        wb.DAT_I = wdat;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge CLK_I);
            #1;
            if (wb.ACK_O) got = 1'b1;
        end
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;
        wb.WE_I  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: ACK=0 expected 1 within 16 cycles", nm);
        end
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string nm);
        wb_access(1'b0, adr, 32'h0, exp, 1'b1, nm);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        wb_access(1'b1, adr, wdat, 32'h0, 1'b0, "write");
    endtask

    // Streams n frames back to back; the last one is cut after last_bits bits.
    task automatic send_stream(input int n, input int last_bits);
        int nb;
        ser_ena_i = 1'b0;
        for (int f = 0; f < n; f++) begin
            nb = (f == n - 1) ? last_bits : 10;
            for (int b = 0; b < nb; b++) begin
                ser_data_i = tx_words[f][b];
                repeat (CPB) @(posedge CLK_I);
                #1;
            end
        end
        ser_ena_i  = 1'b1;
        ser_data_i = 1'b0;
        repeat (6) @(posedge CLK_I);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    initial begin
        logic [9:0] t4 [17];
        bit got;
        t4 = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100,
               10'h200, 10'h3FE, 10'h3FD, 10'h3FB, 10'h3F7, 10'h2AA, 10'h155, 10'h0F0};
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;
        wb.WE_I  = 1'b0;
        wb.ADR_I = 32'h0;
        wb.DAT_I = 32'h0;

        // Reset state
        idle(3);
        check("rst_ack", {31'h0, wb.ACK_O}, 32'h0);
        check("rst_dat", wb.DAT_O, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        RST_I = 1'b0;
        idle(2);
        wb_read(32'h4, 32'h0000_0001, "rst_status");
        wb_read(32'h8, 32'h0000_0000, "rst_ctrl");

        // 1: single frame
        wb_write(32'h8, 32'h1);
        tx_words[0] = 10'h201;
        send_stream(1, 10);
        check("t1_irq", {31'h0, irq_o}, 32'h1);
        wb_read(32'h0, 32'h8000_0201, "t1_data");
        wb_read(32'h4, 32'h0000_0001, "t1_status");
        wb_read(32'hC, 32'h0000_0001, "t1_frames");
        check("t1_irq_clear", {31'h0, irq_o}, 32'h0);

        // 2: back-to-back frames
        tx_words[0] = 10'h3FF;
        tx_words[1] = 10'h000;
        tx_words[2] = 10'h155;
        send_stream(3, 10);
        wb_read(32'h0, 32'h8000_03FF, "t2_data0");
        wb_read(32'h0, 32'h8000_0000, "t2_data1");
        wb_read(32'h0, 32'h8000_0155, "t2_data2");
        wb_read(32'h4, 32'h0000_0001, "t2_status");
        wb_read(32'hC, 32'h0000_0004, "t2_frames");

        // 3: abort after 5 bits, then a clean frame
        tx_words[0] = 10'h3C3;
        send_stream(1, 5);
        wb_read(32'h4, 32'h0000_0009, "t3_status");
        wb_read(32'hC, 32'h0000_0004, "t3_frames");
        wb_read(32'h0, 32'h0000_0000, "t3_empty_read");
        tx_words[0] = 10'h0AA;
        send_stream(1, 10);
        wb_read(32'h0, 32'h8000_00AA, "t3_data");
        wb_write(32'h4, 32'hFFFF_FFFF);
        wb_read(32'h4, 32'h0000_0009, "t3_ro_write");

        // 4: overflow with 17 frames
        wb_write(32'h8, 32'h3);
        wb_read(32'h4, 32'h0000_0001, "t4_clr_status");
        for (int i = 0; i < 17; i++) tx_words[i] = t4[i];
        send_stream(17, 10);
        wb_read(32'h4, 32'h0000_1006, "t4_status");
        wb_read(32'hC, 32'h0000_0011, "t4_frames");
        for (int i = 0; i < 12; i++) begin
            wb_read(32'h0, {1'b1, 21'h0, t4[i]}, $sformatf("t4_data%0d", i));
        end
        wb_read(32'h4, 32'h0000_0404, "t4_status_after");

        // 5: CLR mid-frame with 4 words queued
        tx_words[0] = 10'h1E1;
        fork
            send_stream(1, 10);
            begin
                idle(15);
                wb_write(32'h8, 32'h3);
            end
        join
        wb_read(32'h4, 32'h0000_0001, "t5_status");
        wb_read(32'hC, 32'h0000_0000, "t5_frames");
        wb_read(32'h0, 32'h0000_0000, "t5_data");
        wb_read(32'h8, 32'h0000_0001, "t5_ctrl");
        check("t5_irq", {31'h0, irq_o}, 32'h0);

        // 6a: reset during an ACK cycle
        tx_words[0] = 10'h123;
        send_stream(1, 10);
        check("t6_irq_pre", {31'h0, irq_o}, 32'h1);
        wb.CYC_I = 1'b1;
        wb.STB_I = 1'b1;
        wb.WE_I  = 1'b0;
        wb.ADR_I = 32'h0;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge CLK_I);
            #1;
            if (wb.ACK_O) got = 1'b1;
        end
        check("t6_ack_seen", {31'h0, got}, 32'h1);
        RST_I = 1'b1;
        #1;
        check("t6_ack_rst", {31'h0, wb.ACK_O}, 32'h0);
        check("t6_dat_rst", wb.DAT_O, 32'h0);
        check("t6_irq_rst", {31'h0, irq_o}, 32'h0);
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        idle(2);
        check("t6_ack_after", {31'h0, wb.ACK_O}, 32'h0);
        wb_read(32'h8, 32'h0000_0000, "t6_ctrl");
        wb_read(32'h4, 32'h0000_0001, "t6_status");

        // 6b: reset during bit 6
        wb_write(32'h8, 32'h1);
        tx_words[0] = 10'h0F0;
        send_stream(1, 10);
        check("t6b_irq_pre", {31'h0, irq_o}, 32'h1);
        tx_words[0] = 10'h2D2;
        fork
            send_stream(1, 10);
            begin
                idle(25);
                RST_I = 1'b1;
                #1;
                check("t6b_irq_rst", {31'h0, irq_o}, 32'h0);
                check("t6b_ack_rst", {31'h0, wb.ACK_O}, 32'h0);
                check("t6b_dat_rst", wb.DAT_O, 32'h0);
                @(posedge CLK_I);
                #1;
                RST_I = 1'b0;
            end
        join
        idle(4);
        check("t6b_irq_post", {31'h0, irq_o}, 32'h0);
        wb_read(32'h4, 32'h0000_0001, "t6b_status");
        wb_read(32'hC, 32'h0000_0000, "t6b_frames");
        wb_read(32'h8, 32'h0000_0000, "t6b_ctrl");
        wb_read(32'h0, 32'h0000_0000, "t6b_data");

        idle(4);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/deser_rx_wb.md
# deser_rx_wb

Serial-frame receiver with a Wishbone slave read port. Sits directly downstream of the Wishbone-configured serial transmitter: it consumes that block's `ena`/`data` bit stream, assembles 10-bit LSB-first frames, buffers them in a FIFO and hands them to the bus master via register reads. It replaces the bench-side bit capture with synthesizable RTL.

## Interface
- `CLKS_PER_BIT`, 4: `CLK_I` cycles per serial bit; even, ≥2.
- `FIFO_DEPTH`, 16: received-word FIFO entries; power of 2, ≥2.
- `CLK_I` in 1: single clock; all logic rises on it.
- `RST_I` in 1: asynchronous, active-high reset.
- `ser_ena_i` in 1: frame gate from the transmitter; high = idle, low = frames streaming.
- `ser_data_i` in 1: serial data, LSB first.
- `CYC_I` in 1: Wishbone cycle.
- `STB_I` in 1: Wishbone strobe.
- `WE_I` in 1: Wishbone write enable.
- `ADR_I` in 32: byte address; only `[3:2]` decoded.
- `DAT_I` in 32: write data.
- `DAT_O` out 32: read data; reset 0.
- `ACK_O` out 1: Wishbone acknowledge; reset 0.
- `irq_o` out 1: high when `CTRL.EN` = 1 and the FIFO is not empty; reset 0.

## Operation
- Register map, selected by `ADR_I[3:2]`:
  - 0x0 DATA (RO): pops the FIFO. `[9:0]` word, `[31]` valid. Reading when empty returns 0 and does not pop.
  - 0x4 STATUS (RO): `[0]` empty, `[1]` full, `[2]` overflow (sticky), `[3]` abort (sticky), `[15:8]` FIFO level.
  - 0x8 CTRL (RW): `[0]` EN (reset 0), `[1]` CLR (write-1, self-clearing: flushes the FIFO and clears the stickies and FRAMES). Reads return `[1]` = 0.
  - 0xC FRAMES (RO): `[15:0]` count of completed frames; wraps from 0xFFFF to 0.
- Writes to RO addresses are acknowledged and ignored.
- Receive FSM:
  - IDLE: waits for a `ser_ena_i` 1→0 transition with EN = 1.
  - SHIFT: a clock counter and a 4-bit bit counter run. After bit 9 the frame is pushed and SHIFT continues straight into the next frame while `ser_ena_i` stays low.
  - `ser_ena_i` returning high mid-frame: drop the partial frame, set abort, go to IDLE. Returning high exactly after the bit-9 sample is not an abort.
  - EN cleared mid-frame: go to IDLE, discard the partial frame, no flag.
- FIFO full on push: the word is dropped and overflow is set. A push and a pop in the same cycle while full are both accepted.
- CLR in the same cycle as a push: CLR wins, and the word is discarded.

## Timing
- Let E be the first cycle in which the registered `ser_ena_i` is seen falling.
  - Bit i is sampled at E + CLKS_PER_BIT/2 + i·CLKS_PER_BIT (mid-bit).
  - The push happens one cycle after the bit-9 sample. The word is readable the following cycle.
  - Bit 0 of the next frame is sampled at E + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT.
- Wishbone:
  - `ACK_O` pulses high for one cycle, in the cycle after `CYC_I & STB_I` is sampled high while `ACK_O` is low.
  - `DAT_O` is valid in that same cycle. The pop occurs on that ACK edge.
  - A master holding STB gets an ACK every second cycle. STB must drop in the ACK cycle to avoid a repeat access.
- `irq_o` is registered and updates one cycle after a FIFO level change.
- `RST_I` asserted at any time (including mid-frame or mid-bus-cycle):
  - All registers clear immediately, FSM goes to IDLE, FIFO goes empty.
  - `ACK_O`, `DAT_O` and `irq_o` go to 0 and no partial ACK is completed.

## Configuration
- `DESER_RX_SYNC_EN` defined: `ser_ena_i` and `ser_data_i` pass through a 2-flop synchronizer before the edge detector and sampler. All serial timings above shift by +2 cycles; the bus side is unchanged.
- Undefined: the inputs are registered once and are required to be synchronous to `CLK_I`.

## Structure
- `deser_rx_pkg`: `WORD_W` = 10, register offsets, CTRL/STATUS bit indices, FSM state enum {IDLE, SHIFT}.
- Sub-module `deser_rx_fifo`:
  - Synchronous FIFO parameterized by width and depth.
  - Flush input; full, empty and level outputs.
  - Same-cycle push+pop when full is allowed.
- The top level holds the FSM, the counters, the register file and the Wishbone slave.

## Test plan
1. Reset, write CTRL = 1, send frame 10'h201 (CLKS_PER_BIT = 4) → `irq_o` = 1; DATA read returns 0x8000_0201; STATUS reads 0x0000_0001; FRAMES reads 1.
2. Three back-to-back frames 0x3FF, 0x000, 0x155 with `ser_ena_i` held low → three DATA reads in order return 0x8000_03FF, 0x8000_0000, 0x8000_0155; abort = 0.
3. Drop `ser_ena_i` high after 5 bits → STATUS[3] = 1, FIFO empty, FRAMES unchanged; a following full frame 0x0AA is received correctly.
4. Send 17 frames without reading (FIFO_DEPTH = 16) → STATUS full = 1, overflow = 1, level = 16. The 17th word is absent: the first DATA read returns frame 1.
5. Write CTRL = 0x3 mid-frame with 4 words queued → FIFO empty, stickies cleared, FRAMES = 0, and the next DATA read returns 0x0000_0000.
6. Assert `RST_I` for one cycle during bit 6 and during an ACK cycle → `ACK_O`, `DAT_O`, `irq_o` = 0 at once; EN = 0; no word is pushed afterwards.
